swc_rtu_rsp_queue: RTL and testbench

SWC_RTU_RSP_QUEUE -- requirements
Module: swc_rtu_rsp_queue

---
 rtl/swc_rtu_rsp_queue_if.sv | 28 ++
 rtl/swc_rtu_rsp_queue.sv | 111 +++++++++++
 tb/tb_swc_rtu_rsp_queue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/swc_rtu_rsp_queue_if.sv
// RTU response queue handshake bundle: decision write side plus show-ahead head/ack side.
// The slave modport is the queue, the master modport is its surroundings.
interface swc_rtu_rsp_queue_if #(
  parameter int g_num_ports  = 16,
  parameter int g_prio_width = 3
);
  logic                    in_valid_i;
  logic [g_num_ports-1:0]  in_dst_mask_i;
  logic                    in_drop_i;
  logic [g_prio_width-1:0] in_prio_i;
  logic                    in_full_o;

  logic                    rtu_rsp_valid_o;
  logic                    rtu_rsp_ack_i;
  logic [g_num_ports-1:0]  rtu_dst_port_mask_o;
  logic                    rtu_drop_o;
  logic [g_prio_width-1:0] rtu_prio_o;

  modport slave (
    input  in_valid_i, in_dst_mask_i, in_drop_i, in_prio_i, rtu_rsp_ack_i,
    output in_full_o, rtu_rsp_valid_o, rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o
  );

  modport master (
    output in_valid_i, in_dst_mask_i, in_drop_i, in_prio_i, rtu_rsp_ack_i,
    input  in_full_o, rtu_rsp_valid_o, rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o
  );
endinterface

// File: rtl/swc_rtu_rsp_queue.sv
// RTU decision FIFO with registered show-ahead head; write-to-valid latency 1 cycle.
// Writes while full are dropped and flagged sticky in overflow_o; acks while empty are ignored.
module swc_rtu_rsp_queue #(
  parameter int g_num_ports  = 16,
  parameter int g_prio_width = 3,
  parameter int g_depth      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  swc_rtu_rsp_queue_if.slave         rsp_if,
  output logic [$clog2(g_depth):0]   count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(g_depth);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(g_depth);

  typedef struct packed {
    logic [g_num_ports-1:0]  mask;
    logic                    drop;
    logic [g_prio_width-1:0] prio;
  } entry_t;

  entry_t        mem_q [g_depth];
  entry_t        head_q, head_d;
  entry_t        wr_entry;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          run_q;
  logic          wr_en, rd_en;

  // run_q stays low for the first edge after reset release so that
  // a write or ack presented in the release cycle is ignored.
  always_comb begin
    wr_entry.mask = rsp_if.in_dst_mask_i;
    wr_entry.drop = rsp_if.in_drop_i | ~(|rsp_if.in_dst_mask_i);
    wr_entry.prio = rsp_if.in_prio_i;

    wr_en = run_q & rsp_if.in_valid_i & ~full_q;
    rd_en = run_q & rsp_if.rtu_rsp_ack_i & valid_q;

    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    full_d  = (count_d == DEPTH_C);
    valid_d = (count_d != '0);
    ovf_d   = ovf_q | (run_q & rsp_if.in_valid_i & full_q);

    // Refill the head whenever it is consumed or the queue leaves empty;
    // the new head bypasses memory when it is being written this cycle.
    head_d = head_q;
    if ((rd_en || !valid_q) && valid_d) begin
      if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
        head_d = wr_entry;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
      run_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
      run_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign rsp_if.in_full_o           = full_q;
  assign rsp_if.rtu_rsp_valid_o     = valid_q;
  assign rsp_if.rtu_dst_port_mask_o = head_q.mask;
  assign rsp_if.rtu_drop_o          = head_q.drop;
  assign rsp_if.rtu_prio_o          = head_q.prio;
  assign count_o                    = count_q;
  assign overflow_o                 = ovf_q;

endmodule

// File: tb/tb_swc_rtu_rsp_queue.sv
// Directed bench for swc_rtu_rsp_queue with a queue-based scoreboard of expected head entries.
module tb_swc_rtu_rsp_queue;

  typedef struct packed {
    logic [15:0] mask;
    logic        drop;
    logic [2:0]  prio;
  } ent_t;

  logic       clk;
  logic       rst;
  logic [2:0] count;
  logic       overflow;

  ent_t sb[$];
  int   m_cnt;
  bit   m_ovf;
  int   tests;
  int   fails;

  swc_rtu_rsp_queue_if #(.g_num_ports(16), .g_prio_width(3)) rsp_if ();

  swc_rtu_rsp_queue #(.g_num_ports(16), .g_prio_width(3), .g_depth(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rsp_if     (rsp_if),
    .count_o    (count),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_cnt));
    chk({tag, ".valid"}, 32'(rsp_if.rtu_rsp_valid_o), 32'(m_cnt != 0));
    chk({tag, ".full"}, 32'(rsp_if.in_full_o), 32'(m_cnt == 4));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    if (m_cnt != 0) begin
      chk({tag, ".mask"}, 32'(rsp_if.rtu_dst_port_mask_o), 32'(sb[0].mask));
      chk({tag, ".drop"}, 32'(rsp_if.rtu_drop_o), 32'(sb[0].drop));
      chk({tag, ".prio"}, 32'(rsp_if.rtu_prio_o), 32'(sb[0].prio));
    end
  endtask

  task automatic drive_idle();
    rsp_if.in_valid_i    = 1'b0;
    rsp_if.in_dst_mask_i = '0;
    rsp_if.in_drop_i     = 1'b0;
    rsp_if.in_prio_i     = '0;
    rsp_if.rtu_rsp_ack_i = 1'b0;
  endtask

  // One clock: drive, predict, clock, update scoreboard, check.
  task automatic step(input string tag, input bit vld, input logic [15:0] mask,
                      input bit drop, input logic [2:0] prio, input bit ack);
    ent_t e;
    ent_t gone;
    bit   aw;
    bit   ar;
    rsp_if.in_valid_i    = vld;
    rsp_if.in_dst_mask_i = mask;
    rsp_if.in_drop_i     = drop;
    rsp_if.in_prio_i     = prio;
    rsp_if.rtu_rsp_ack_i = ack;
    aw     = vld && (m_cnt < 4);
    ar     = ack && (m_cnt > 0);
    e.mask = mask;
    e.drop = drop || (mask == 16'h0);
    e.prio = prio;
    if (vld && m_cnt == 4) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    drive_idle();
    if (ar) begin
      gone = sb.pop_front();
      m_cnt--;
    end
    if (aw) begin
      sb.push_back(e);
      m_cnt++;
    end
    check_state(tag);
  endtask

  task automatic wr(input string tag, input logic [15:0] mask, input logic [2:0] prio);
    step(tag, 1'b1, mask, 1'b0, prio, 1'b0);
  endtask

  task automatic ack(input string tag);
    step(tag, 1'b0, 16'h0, 1'b0, 3'd0, 1'b1);
  endtask

  // Async reset applied mid-cycle, checked before any edge, then released
  // with a write+ack presented in the release cycle that must be ignored.
  task automatic reset_cycle(input string tag);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    chk({tag, ".async_valid"}, 32'(rsp_if.rtu_rsp_valid_o), 32'd0);
    chk({tag, ".async_count"}, 32'(count), 32'd0);
    chk({tag, ".async_ovf"}, 32'(overflow), 32'd0);
    chk({tag, ".async_full"}, 32'(rsp_if.in_full_o), 32'd0);
    chk({tag, ".async_mask"}, 32'(rsp_if.rtu_dst_port_mask_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_if.in_valid_i    = 1'b1;
    rsp_if.in_dst_mask_i = 16'hBEEF;
    rsp_if.rtu_rsp_ack_i = 1'b1;
    @(posedge clk);
    #1;
    drive_idle();
    check_state({tag, ".release"});
  endtask

  logic [15:0] fill_masks [5];

  initial begin
    tests = 0;
    fails = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    rst   = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.valid", 32'(rsp_if.rtu_rsp_valid_o), 32'd0);
    chk("rst.full", 32'(rsp_if.in_full_o), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    chk("rst.mask", 32'(rsp_if.rtu_dst_port_mask_o), 32'd0);
    chk("rst.drop", 32'(rsp_if.rtu_drop_o), 32'd0);
    chk("rst.prio", 32'(rsp_if.rtu_prio_o), 32'd0);
    rst = 1'b0;
    step("release", 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);

    // single entry
    wr("single.wr", 16'h0005, 3'd6);
    chk("single.mask_lit", 32'(rsp_if.rtu_dst_port_mask_o), 32'h5);
    chk("single.prio_lit", 32'(rsp_if.rtu_prio_o), 32'd6);
    ack("single.ack");
    chk("single.empty_lit", 32'(rsp_if.rtu_rsp_valid_o), 32'd0);

    // zero mask forces drop
    wr("zero.wr", 16'h0000, 3'd3);
    chk("zero.drop_lit", 32'(rsp_if.rtu_drop_o), 32'd1);
    ack("zero.ack");

    // spurious ack on empty
    ack("spur.ack");
    ack("spur.ack2");
    chk("spur.count_lit", 32'(count), 32'd0);
    wr("spur.wr", 16'h00A0, 3'd1);
    ack("spur.drain");

    // write+ack at count 1, then at count 2
    wr("c1.wr", 16'h0011, 3'd1);
    step("c1.wr_ack", 1'b1, 16'h0022, 1'b0, 3'd2, 1'b1);
    chk("c1.head_lit", 32'(rsp_if.rtu_dst_port_mask_o), 32'h22);
    wr("c2.wr", 16'h0033, 3'd3);
    step("c2.wr_ack", 1'b1, 16'h0044, 1'b1, 3'd4, 1'b1);
    chk("c2.count_lit", 32'(count), 32'd2);
    ack("c2.ack0");
    ack("c2.ack1");

    // fill and overflow
    fill_masks[0] = 16'h0001;
    fill_masks[1] = 16'h0002;
    fill_masks[2] = 16'h0004;
    fill_masks[3] = 16'h0008;
    fill_masks[4] = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      wr($sformatf("fill.wr%0d", i), fill_masks[i], 3'(i));
      if (i == 3) chk("fill.full_lit", 32'(rsp_if.in_full_o), 32'd1);
    end
    chk("fill.ovf_lit", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill.order%0d", i), 32'(rsp_if.rtu_dst_port_mask_o), 32'(fill_masks[i]));
      ack($sformatf("fill.ack%0d", i));
    end

    // full plus simultaneous write+ack, starting from a clean overflow flag
    reset_cycle("rst1");
    wr("post_rst.wr", 16'h0100, 3'd5);
    chk("post_rst.mask_lit", 32'(rsp_if.rtu_dst_port_mask_o), 32'h100);
    for (int i = 0; i < 3; i++) wr($sformatf("full.wr%0d", i), 16'(16'h0200 << i), 3'(i));
    step("full.wr_ack", 1'b1, 16'hFFFF, 1'b0, 3'd7, 1'b1);
    chk("full.count_lit", 32'(count), 32'd3);
    chk("full.ovf_lit", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) ack($sformatf("full.ack%0d", i));

    // wrap: 10 write/ack pairs
    wr("wrap.wr0", 16'h1000, 3'd0);
    for (int i = 1; i < 10; i++) begin
      step($sformatf("wrap.pair%0d", i), 1'b1, 16'(16'h1000 + i),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
    end
    ack("wrap.last");

    // mid-operation reset with 3 entries held and overflow set
    for (int i = 0; i < 5; i++) wr($sformatf("pre_rst.wr%0d", i), 16'(16'h0040 + i), 3'd2);
    ack("pre_rst.ack");
    chk("pre_rst.count_lit", 32'(count), 32'd3);
    reset_cycle("rst2");
    wr("rst2.first_wr", 16'h8001, 3'd4);
    ack("rst2.ack");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
